// File: rtl/usr_ctrl_if.sv
// Command/handshake and shift-register drive bundle for usr_ctrl.
// The master side issues commands; the slave side (usr_ctrl) drives sel/data/status.
interface usr_ctrl_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [1:0]                cmd_op;
    logic [CNT_W-1:0]          cmd_count;
    logic [WIDTH-1:0]          cmd_data;
    logic [(1 << CNT_W)-1:0]   cmd_serial;
    logic                      abort;
    logic [1:0]                sel;
    logic [WIDTH-1:0]          data_out;
    logic                      shift_right_data;
    logic                      shift_left_data;
    logic                      busy;
    logic                      done;
    logic                      aborted;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_serial, abort,
        input  cmd_ready, sel, data_out, shift_right_data, shift_left_data,
               busy, done, aborted
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_data, cmd_serial, abort,
        output cmd_ready, sel, data_out, shift_right_data, shift_left_data,
               busy, done, aborted
    );
endinterface

// File: rtl/usr_ctrl.sv
// Command sequencer for a universal shift register: accepts nop/shift/load
// commands and drives registered sel, parallel data and serial input bits.
module usr_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input logic       clk,
    input logic       reset,
    usr_ctrl_if.slave bus
);
    localparam int unsigned PW = 1 << CNT_W;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       sel_q, sel_d;
    logic [PW-1:0]    pat_q, pat_d;
    logic [CNT_W:0]   rem_q, rem_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             srd_q, srd_d;
    logic             sld_q, sld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        pat_d      = pat_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        data_out_d = data_out_q;
        sel_d      = 2'b00;
        srd_d      = 1'b0;
        sld_d      = 1'b0;
        done_d     = 1'b0;
        aborted_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d  = bus.cmd_op;
                    pat_d = bus.cmd_serial;
                    // Extra MSB lets a count of 0 stand for 2^CNT_W without wrapping.
                    rem_d = {(bus.cmd_count == '0), bus.cmd_count};
                    idx_d = '0;
                    case (bus.cmd_op)
                        2'b11: begin
                            state_d    = LOAD;
                            sel_d      = 2'b11;
                            data_out_d = bus.cmd_data;
                        end
                        2'b01, 2'b10: begin
                            state_d = SHIFT;
                            sel_d   = bus.cmd_op;
                            srd_d   = (bus.cmd_op == 2'b01) & bus.cmd_serial[0];
                            sld_d   = (bus.cmd_op == 2'b10) & bus.cmd_serial[0];
                        end
                        default: begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
            LOAD: begin
                state_d   = DONE;
                done_d    = 1'b1;
                aborted_d = bus.abort;
            end
            SHIFT: begin
                if (bus.abort || rem_q == (CNT_W+1)'(1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    aborted_d = bus.abort;
                end else begin
                    rem_d = rem_q - (CNT_W+1)'(1);
                    idx_d = idx_q + CNT_W'(1);
                    sel_d = op_q;
                    srd_d = (op_q == 2'b01) & pat_q[idx_d];
                    sld_d = (op_q == 2'b10) & pat_q[idx_d];
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            pat_q      <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
            data_out_q <= '0;
            sel_q      <= 2'b00;
            srd_q      <= 1'b0;
            sld_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            pat_q      <= pat_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            data_out_q <= data_out_d;
            sel_q      <= sel_d;
            srd_q      <= srd_d;
            sld_q      <= sld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign bus.cmd_ready        = (state_q == IDLE) && reset;
    assign bus.sel              = sel_q;
    assign bus.data_out         = data_out_q;
    assign bus.shift_right_data = srd_q;
    assign bus.shift_left_data  = sld_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.aborted          = aborted_q;
endmodule

// File: tb/tb_usr_ctrl.sv
// Directed bench for usr_ctrl: per-cycle vector table plus hand-written
// sequences for abort, asynchronous reset and back-to-back commands.
module tb_usr_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    usr_ctrl_if #(.WIDTH(4), .CNT_W(3)) bus ();

    usr_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [2:0] cnt;
        logic [3:0] data;
        logic [7:0] ser;
        logic       ab;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Observed outputs packed as {rdy, sel[1:0], dout[3:0], srd, sld, busy, done, aborted}.
    function automatic logic [11:0] obs();
        return {bus.cmd_ready, bus.sel, bus.data_out, bus.shift_right_data,
                bus.shift_left_data, bus.busy, bus.done, bus.aborted};
    endfunction

    task automatic add(input logic v, input logic [1:0] op, input logic [2:0] cnt,
                       input logic [3:0] data, input logic [7:0] ser, input logic ab,
                       input logic rdy, input logic [1:0] sel, input logic [3:0] dout,
                       input logic srd, input logic sld, input logic busy,
                       input logic dn, input logic abt);
        vec_t r;
        r.v = v; r.op = op; r.cnt = cnt; r.data = data; r.ser = ser; r.ab = ab;
        r.exp = {rdy, sel, dout, srd, sld, busy, dn, abt};
        tbl.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] cnt,
                         input logic [3:0] data, input logic [7:0] ser, input logic ab);
        bus.cmd_valid = v; bus.cmd_op = op; bus.cmd_count = cnt;
        bus.cmd_data = data; bus.cmd_serial = ser; bus.abort = ab;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(0, 2'b00, 3'd0, 4'h0, 8'h00, 0);

        #3;
        chk("reset_state", {20'd0, obs()}, 32'd0);

        // load 1010; op/data changes after acceptance must be ignored
        add(1,2'b11,3'd0,4'hA,8'h00,0, 1,2'b00,4'h0,0,0,0,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,0, 0,2'b11,4'hA,0,0,1,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,0, 0,2'b00,4'hA,0,0,1,1,0);
        // shift right, count 3, pattern 0000_0101
        add(1,2'b01,3'd3,4'h0,8'h05,0, 1,2'b00,4'hA,0,0,0,0,0);
        add(0,2'b11,3'd1,4'hF,8'hFA,0, 0,2'b01,4'hA,1,0,1,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,0, 0,2'b01,4'hA,0,0,1,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,0, 0,2'b01,4'hA,1,0,1,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,0, 0,2'b00,4'hA,0,0,1,1,0);
        // shift left, count 0 => 8 cycles, pattern A5
        add(1,2'b10,3'd0,4'h0,8'hA5,0, 1,2'b00,4'hA,0,0,0,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,0, 0,2'b10,4'hA,0,1,1,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,0, 0,2'b10,4'hA,0,0,1,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,0, 0,2'b10,4'hA,0,1,1,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,0, 0,2'b10,4'hA,0,0,1,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,0, 0,2'b10,4'hA,0,0,1,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,0, 0,2'b10,4'hA,0,1,1,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,0, 0,2'b10,4'hA,0,0,1,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,0, 0,2'b10,4'hA,0,1,1,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,0, 0,2'b00,4'hA,0,0,1,1,0);
        // nop accepted together with abort; abort in DONE/IDLE ignored
        add(1,2'b00,3'd0,4'h0,8'h00,1, 1,2'b00,4'hA,0,0,0,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,1, 0,2'b00,4'hA,0,0,1,1,0);
        add(0,2'b00,3'd0,4'h0,8'h00,1, 1,2'b00,4'hA,0,0,0,0,0);
        // load 0101 aborted during LOAD
        add(1,2'b11,3'd0,4'h5,8'h00,0, 1,2'b00,4'hA,0,0,0,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,1, 0,2'b11,4'h5,0,0,1,0,0);
        add(0,2'b00,3'd0,4'h0,8'h00,0, 0,2'b00,4'h5,0,0,1,1,1);
        add(0,2'b00,3'd0,4'h0,8'h00,0, 1,2'b00,4'h5,0,0,0,0,0);

        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].op, tbl[i].cnt, tbl[i].data, tbl[i].ser, tbl[i].ab);
            chk($sformatf("row%0d", i), {20'd0, obs()}, {20'd0, tbl[i].exp});
        end

        // abort on the 2nd shift cycle of a count-5 right shift (pattern bits 0,1 = 0,1)
        @(negedge clk);
        drive(1, 2'b01, 3'd5, 4'h0, 8'b0001_0110, 0);
        chk("abt_idle_rdy", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        drive(0, 2'b00, 3'd0, 4'h0, 8'h00, 0);
        chk("abt_c1_sel", {30'd0, bus.sel}, 32'd1);
        chk("abt_c1_srd", {31'd0, bus.shift_right_data}, 32'd0);
        @(negedge clk);
        bus.abort = 1'b1;
        chk("abt_c2_sel", {30'd0, bus.sel}, 32'd1);
        chk("abt_c2_srd", {31'd0, bus.shift_right_data}, 32'd1);
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abt_done", {29'd0, bus.sel, bus.done}, 32'd1);
        chk("abt_flag", {31'd0, bus.aborted}, 32'd1);
        @(negedge clk);
        chk("abt_back_idle", {29'd0, bus.cmd_ready, bus.busy, bus.done}, 32'd4);

        // asynchronous reset in the middle of an 8-cycle left shift
        drive(1, 2'b10, 3'd0, 4'h0, 8'hFF, 0);
        @(negedge clk);
        drive(0, 2'b00, 3'd0, 4'h0, 8'h00, 0);
        @(posedge clk);
        #2;
        chk("rst_pre_sel", {30'd0, bus.sel}, 32'd2);
        reset = 1'b0;
        #1;
        chk("rst_async", {20'd0, obs()}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_hold%0d", i), {20'd0, obs()}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rdy_after", {29'd0, bus.cmd_ready, bus.busy, bus.done}, 32'd4);
        @(negedge clk);
        chk("rst_no_done", {31'd0, bus.done}, 32'd0);

        // back-to-back: valid held high, shift-right count 2 then a nop
        drive(1, 2'b01, 3'd2, 4'h0, 8'h03, 0);
        @(negedge clk);
        chk("b2b_c1", {28'd0, bus.cmd_ready, bus.sel, bus.shift_right_data}, 32'h3);
        @(negedge clk);
        chk("b2b_c2", {28'd0, bus.cmd_ready, bus.sel, bus.shift_right_data}, 32'h3);
        bus.cmd_op = 2'b00;
        @(negedge clk);
        chk("b2b_done1", {29'd0, bus.cmd_ready, bus.sel[0], bus.done}, 32'd1);
        @(negedge clk);
        chk("b2b_rdy", {29'd0, bus.cmd_ready, bus.busy, bus.done}, 32'd4);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("b2b_nop_done", {28'd0, bus.cmd_ready, bus.sel, bus.done}, 32'd1);
        chk("b2b_nop_abt", {31'd0, bus.aborted}, 32'd0);
        @(negedge clk);
        chk("b2b_idle", {29'd0, bus.cmd_ready, bus.busy, bus.done}, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
